// File: rtl/mxint_block_sum_stream.sv
// Streaming MX block summer: shared E8M0 scale + BLOCK_SIZE signed elements in LANES-wide
// beats, exact accumulation, one normalisation cycle to float32. Option: MXINT_SUM_SUBNORMAL_EN.
module mxint_block_sum_stream #(
    parameter int ELEM_WIDTH  = 8,
    parameter int BLOCK_SIZE  = 32,
    parameter int LANES       = 4,
    parameter int SCALE_WIDTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [SCALE_WIDTH-1:0]      i_scale,
    input  logic [LANES*ELEM_WIDTH-1:0] i_elements,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [31:0]                 o_float32,
    output logic                        o_overflow,
    output logic                        o_underflow
);
    localparam int ACC_W  = ELEM_WIDTH + $clog2(BLOCK_SIZE) + 1;
    localparam int BEATS  = BLOCK_SIZE / LANES;
    localparam int CNT_W  = $clog2(BEATS + 1);
    localparam int P_W    = $clog2(ACC_W);
    localparam int EXP_W  = SCALE_WIDTH + 4;
    localparam int NORM_W = ACC_W + 23;

    typedef enum logic [1:0] {IDLE, ACCUM, NORM, OUT} state_t;
    state_t state, state_nxt;

    logic [SCALE_WIDTH-1:0] scale_q;
    logic [ACC_W-1:0]       acc;
    logic [CNT_W-1:0]       count;
    logic [ACC_W-1:0]       lane_sum;
    logic                   beat;
    logic                   last_beat;

    logic                   sgn;
    logic [ACC_W-1:0]       mag;
    logic [P_W-1:0]         p;
    logic [NORM_W-1:0]      norm;
    logic [22:0]            frac;
    logic [EXP_W-1:0]       e;
    logic                   e_ovf;
    logic                   e_nonpos;
    logic [31:0]            res_f;
    logic                   res_ov;
    logic                   res_uf;
`ifdef MXINT_SUM_SUBNORMAL_EN
    logic [EXP_W-1:0]       sub_sh;
    logic [23:0]            sub_m;
`endif

    always_comb begin
        lane_sum = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + ACC_W'($signed(i_elements[k*ELEM_WIDTH +: ELEM_WIDTH]));
        end
    end

    assign beat      = i_valid && o_ready;
    assign last_beat = (state == IDLE) ? (BEATS == 1) : (count == CNT_W'(BEATS - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (beat) state_nxt = last_beat ? NORM : ACCUM;
            ACCUM:   if (beat && last_beat) state_nxt = NORM;
            NORM:    state_nxt = OUT;
            OUT:     if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state)
            IDLE, ACCUM: o_ready = !i_rst;
            OUT:         o_valid = 1'b1;
            default:     ;
        endcase
    end

    // Leading one of |sum| lands at bit 23 of norm; everything below it is the fraction.
    always_comb begin
        sgn      = acc[ACC_W-1];
        mag      = sgn ? (~acc + ACC_W'(1)) : acc;
        p        = '0;
        for (int unsigned i = 0; i < ACC_W; i++) begin
            if (mag[i]) p = P_W'(i);
        end
        norm     = {mag, 23'b0} >> p;
        frac     = norm[22:0];
        e        = EXP_W'(scale_q) - EXP_W'(ELEM_WIDTH - 2) + EXP_W'(p);
        e_ovf    = !e[EXP_W-1] && (e >= EXP_W'(255));
        e_nonpos = e[EXP_W-1] || (e == '0);
`ifdef MXINT_SUM_SUBNORMAL_EN
        sub_sh   = EXP_W'(1) - e;
        sub_m    = {1'b1, frac} >> sub_sh;
`endif
        res_f    = {sgn, e[7:0], frac};
        res_ov   = 1'b0;
        res_uf   = 1'b0;
        if (scale_q == '1) begin
            res_f = 32'h7FC0_0000;
        end else if (norm == '0) begin
            res_f = '0;
        end else if (e_ovf) begin
            res_f  = {sgn, 8'hFF, 23'b0};
            res_ov = 1'b1;
        end else if (e_nonpos) begin
`ifdef MXINT_SUM_SUBNORMAL_EN
            res_f  = {sgn, 8'h00, sub_m[22:0]};
            res_uf = (sub_m == '0) || ((sub_m << sub_sh) != {1'b1, frac});
`else
            res_f  = {sgn, 31'b0};
            res_uf = 1'b1;
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scale_q     <= '0;
            acc         <= '0;
            count       <= '0;
            o_float32   <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (beat) begin
                if (state == IDLE) begin
                    scale_q <= i_scale;
                    acc     <= lane_sum;
                    count   <= CNT_W'(1);
                end else begin
                    acc     <= acc + lane_sum;
                    count   <= count + CNT_W'(1);
                end
            end
            if (state == NORM) begin
                o_float32   <= res_f;
                o_overflow  <= res_ov;
                o_underflow <= res_uf;
            end
        end
    end
endmodule

// File: tb/tb_mxint_block_sum_stream.sv
// Scoreboard bench for mxint_block_sum_stream: randomized and directed blocks, expected
// float32/flags from an arithmetic model, monitor checks latency, hold and transfers.
`timescale 1ns/1ps
module tb_mxint_block_sum_stream;
    localparam int EW    = 8;
    localparam int BS    = 32;
    localparam int LN    = 4;
    localparam int SW    = 8;
    localparam int BEATS = BS / LN;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b0;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [SW-1:0]     i_scale = '0;
    logic [LN*EW-1:0]  i_elements = '0;
    logic              o_valid;
    logic              i_ready = 1'b0;
    logic [31:0]       o_float32;
    logic              o_overflow;
    logic              o_underflow;

    mxint_block_sum_stream #(
        .ELEM_WIDTH (EW),
        .BLOCK_SIZE (BS),
        .LANES      (LN),
        .SCALE_WIDTH(SW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_scale    (i_scale),
        .i_elements (i_elements),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_float32  (o_float32),
        .o_overflow (o_overflow),
        .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] f;
        logic        ov;
        logic        uf;
        int          exp_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   ready_mode = 2;
    int   blk[BS];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Value = sum * 2^(scale-127-(EW-2)); float32 fields derived directly from that.
    function automatic exp_t model(input int scale, input int sum, input int exp_cyc);
        exp_t   r;
        int     mag, p, e;
        longint fr;
`ifdef MXINT_SUM_SUBNORMAL_EN
        longint m;
        int     sh;
`endif
        r.exp_cyc = exp_cyc;
        r.ov = 1'b0;
        r.uf = 1'b0;
        r.f  = '0;
        if (scale == 255) begin
            r.f = 32'h7FC0_0000;
            return r;
        end
        if (sum == 0) return r;
        mag = (sum < 0) ? -sum : sum;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        e = scale - (EW - 2) + p;
        if (e >= 255) begin
            r.f  = {(sum < 0), 8'hFF, 23'h0};
            r.ov = 1'b1;
            return r;
        end
        if (e <= 0) begin
`ifdef MXINT_SUM_SUBNORMAL_EN
            sh   = scale - 127 - (EW - 2) + 149;
            m    = (sh >= 0) ? (longint'(mag) << sh) : (longint'(mag) >> (-sh));
            r.uf = (m == 0) || (sh < 0 && (m << (-sh)) != longint'(mag));
            r.f  = {(sum < 0), 8'h00, m[22:0]};
`else
            r.f  = {(sum < 0), 31'h0};
            r.uf = 1'b1;
`endif
            return r;
        end
        fr  = ((longint'(mag) - (longint'(1) << p)) << 23) >> p;
        r.f = {(sum < 0), e[7:0], fr[22:0]};
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            case (ready_mode)
                0:       i_ready = ($urandom_range(0, 3) != 0);
                1:       i_ready = 1'b0;
                default: i_ready = 1'b1;
            endcase
        end
    end

    // Monitor: latency on rise, stability while stalled, pop and compare on transfer.
    initial begin
        logic        prev_valid = 1'b0;
        logic        held = 1'b0;
        logic [31:0] held_f;
        logic        held_ov, held_uf;
        exp_t        x;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                prev_valid = 1'b0;
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", o_valid, 1'b1);
                    check("hold_f32", o_float32, held_f);
                    check("hold_flags", {o_overflow, o_underflow}, {held_ov, held_uf});
                end
                held = 1'b0;
                if (o_valid === 1'b1) begin
                    check("ready_low_in_out", o_ready, 1'b0);
                    if (!prev_valid) begin
                        if (sb_q.size() == 0) flag_fail("unexpected_valid");
                        else check("latency_cycle", cyc, sb_q[0].exp_cyc);
                    end
                    if (i_ready) begin
                        if (sb_q.size() > 0) begin
                            x = sb_q.pop_front();
                            check("f32", o_float32, x.f);
                            check("overflow", o_overflow, x.ov);
                            check("underflow", o_underflow, x.uf);
                        end
                    end else begin
                        held    = 1'b1;
                        held_f  = o_float32;
                        held_ov = o_overflow;
                        held_uf = o_underflow;
                    end
                end
                prev_valid = (o_valid === 1'b1);
            end
        end
    end

    task automatic do_reset();
        i_valid = 1'b0;
        i_rst = 1'b1;
        #1;
        check("rst_ready", o_ready, 1'b0);
        check("rst_valid", o_valid, 1'b0);
        check("rst_f32", o_float32, 32'h0);
        check("rst_flags", {o_overflow, o_underflow}, 2'b00);
        sb_q.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    // rst_after < BEATS: reset in place of that beat, after the earlier beats were taken.
    task automatic send_block(input int scale, input int gap, input int rst_after);
        int sum = 0;
        int v;
        int waited;
        for (int i = 0; i < BS; i++) begin
            v = blk[i] & ((1 << EW) - 1);
            if (v >= (1 << (EW - 1))) v -= (1 << EW);
            sum += v;
        end
        for (int b = 0; b < BEATS; b++) begin
            if (b == rst_after) begin
                do_reset();
                return;
            end
            for (int k = 0; k < LN; k++) i_elements[k*EW +: EW] = EW'(blk[b*LN + k]);
            i_scale = (b == 0) ? SW'(scale) : SW'($urandom);
            i_valid = 1'b1;
            waited = 0;
            do begin
                @(negedge i_clk);
                waited++;
            end while (o_ready !== 1'b1 && waited < 100);
            if (o_ready !== 1'b1) begin
                flag_fail("ready_timeout");
                i_valid = 1'b0;
                return;
            end
            if (b == BEATS - 1) sb_q.push_back(model(scale, sum, cyc + 2));
            @(posedge i_clk);
            #1;
            i_valid = 1'b0;
            i_elements = LN*EW'($urandom);
            i_scale = SW'($urandom);
            repeat (gap) begin
                @(posedge i_clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_q.size() != 0 || o_valid === 1'b1) && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        if (sb_q.size() != 0) flag_fail("drain_timeout");
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (o_valid !== 1'b1 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (o_valid !== 1'b1) flag_fail("valid_timeout");
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < BS; i++) blk[i] = v;
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int i = 0; i < BS; i++) blk[i] = $urandom_range(hi, lo) & ((1 << EW) - 1);
    endtask

    initial begin
        int sc, cls;
        #1 i_rst = 1'b1;
        #2;
        check("reset_ready", o_ready, 1'b0);
        check("reset_valid", o_valid, 1'b0);
        check("reset_f32", o_float32, 32'h0);
        check("reset_flags", {o_overflow, o_underflow}, 2'b00);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("ready_after_reset", o_ready, 1'b1);
        @(posedge i_clk);
        #1;

        ready_mode = 2;
        fill_const(8'h40); send_block(127, 0, BEATS);
        fill_const(8'hC0); send_block(127, 0, BEATS);
        for (int i = 0; i < BS; i++) blk[i] = (i % 2 == 0) ? 8'h40 : 8'hC0;
        send_block(127, 0, BEATS);
        fill_rand(0, 255); send_block(255, 0, BEATS);
        fill_const(8'h7F); send_block(250, 0, BEATS);
        fill_const(8'h80); send_block(250, 0, BEATS);
        fill_const(0); blk[0] = 1; send_block(0, 0, BEATS);
        fill_const(0); blk[5] = 8'hFF; send_block(3, 0, BEATS);
        fill_const(0); blk[BS-1] = 8'h7F; send_block(1, 1, BEATS);
        wait_drain();

        fill_const(8'h40); send_block(127, 3, BEATS);
        wait_drain();

        ready_mode = 1;
        fill_rand(0, 255); send_block(130, 0, BEATS);
        wait_valid();
        repeat (5) @(negedge i_clk);
        ready_mode = 2;
        wait_drain();

        fill_rand(0, 255); send_block(120, 0, 4);
        fill_const(8'h40); send_block(127, 0, BEATS);
        wait_drain();

        ready_mode = 1;
        fill_rand(0, 255); send_block(127, 0, BEATS);
        wait_valid();
        repeat (2) @(negedge i_clk);
        do_reset();
        ready_mode = 2;
        fill_const(8'hC0); send_block(127, 0, BEATS);
        wait_drain();

        ready_mode = 0;
        for (int t = 0; t < 40; t++) begin
            cls = $urandom_range(0, 4);
            case (cls)
                0:       sc = $urandom_range(0, 8);
                1:       sc = $urandom_range(240, 254);
                2:       sc = 255;
                default: sc = $urandom_range(0, 254);
            endcase
            if ($urandom_range(0, 3) == 0) fill_rand(0, 3);
            else fill_rand(0, 255);
            if ($urandom_range(0, 4) == 0) fill_const(0);
            send_block(sc, $urandom_range(0, 2), BEATS);
        end
        ready_mode = 2;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mxint_block_sum_stream.md
Name: mxint_block_sum_stream

Overview:
- Streaming, parametrised successor to the combinational MXINT8 block summer.
- Accepts one MX block per transaction: a shared scale plus BLOCK_SIZE signed elements, delivered LANES elements per beat over a valid/ready handshake.
- Accumulates the elements exactly, then normalises the sum into one IEEE-754 float32 in a dedicated cycle.
- Presents the result on a held valid/ready output with overflow and underflow flags. Sits between the MX operand buffers and the float32 reduction tree.

Parameters:
- ELEM_WIDTH, 8, element width in bits; two's complement, value = elem * 2^-(ELEM_WIDTH-2).
- BLOCK_SIZE, 32, elements per block; must be a multiple of LANES.
- LANES, 4, elements accepted per input beat.
- SCALE_WIDTH, 8, shared E8M0 scale width; value 2^(scale-127); all-ones = NaN.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat
- i_scale  in  SCALE_WIDTH  shared scale; sampled on the first beat of a block only
- i_elements  in  LANES*ELEM_WIDTH  packed elements; lane k at bits [k*ELEM_WIDTH +: ELEM_WIDTH]
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_float32  out  32  block sum as float32
- o_overflow  out  1  result saturated to infinity
- o_underflow  out  1  result flushed or denormalised

Behaviour:
- Reset (async, i_rst=1): state IDLE, accumulator 0, beat counter 0. o_ready=0 while in reset, 1 after. o_valid=0, o_float32=0, o_overflow=0, o_underflow=0.
- Reset mid-block or mid-output discards all partial or pending state.
- Beat transfer occurs when i_valid && o_ready. Result transfer occurs when o_valid && i_ready.
- Element order: beat b, lane k holds element b*LANES+k.
- Accumulator width is ACC_W = ELEM_WIDTH + clog2(BLOCK_SIZE) + 1, signed. Each element is sign-extended and added exactly, so the sum never overflows.
- FSM:
  - IDLE: o_ready=1. On a beat, capture scale, load the accumulator with the lane sum, count=1, go to ACCUM. If BLOCK_SIZE==LANES, go directly to NORM.
  - ACCUM: o_ready=1. Each beat adds its lane sum and increments count. On beat number BLOCK_SIZE/LANES, go to NORM. Idle cycles (i_valid=0) hold state.
  - NORM: o_ready=0, one cycle. Compute the result and register it into the outputs, set o_valid=1, go to OUT.
  - OUT: o_ready=0. Outputs are held stable until i_ready=1, then o_valid=0 and go to IDLE.
- No beat is accepted in the cycle a result is taken.
- Latency: o_valid rises 2 cycles after the final beat is accepted. Minimum period is BLOCK_SIZE/LANES + 2 cycles per block.
- Normalisation:
  - sign = sum MSB; mag = |sum|; p = index of the leading one of mag.
  - e = scale - (ELEM_WIDTH-2) + p, computed signed at SCALE_WIDTH+4 bits.
  - mantissa = the bits of mag below p, left-aligned to 23 bits. Bits beyond 23 are truncated (round toward zero).
- Special cases:
  - scale all-ones -> 0x7FC00000, both flags 0; the element values are ignored.
  - mag == 0 -> 0x00000000 (+0), flags 0.
  - e >= 255 -> {sign, 8'hFF, 23'b0}, o_overflow=1.
  - e <= 0 -> {sign, 31'b0}, o_underflow=1, unless the optional feature is enabled.
- Flags are registered together with o_float32 and are valid only while o_valid=1.

Optional Feature:
- Macro: MXINT_SUM_SUBNORMAL_EN.
- When defined and e <= 0, the output is a subnormal: exponent field 0, mantissa = {1, fraction} >> (1-e), truncated. o_underflow=1 only if the result is nonzero bits lost or the result becomes zero.
- When undefined, results with e <= 0 flush to signed zero with o_underflow=1.

Test Plan:
1. Default params; scale=127; all 32 elements 0x40 over 8 beats -> o_float32=0x42000000 (32.0); flags 0; o_valid 2 cycles after beat 8.
2. Same stimulus with all elements 0xC0 -> 0xC2000000. Then elements alternating 0x40/0xC0 -> 0x00000000, flags 0.
3. scale=0xFF with arbitrary elements -> 0x7FC00000, o_overflow=0, o_underflow=0.
4. scale=250; all elements 0x7F (sum 4064, e=255) -> 0x7F800000, o_overflow=1.
5. scale=0; element 0 = 0x01, all others 0 (e=-6):
   - macro undefined -> 0x00000000, o_underflow=1.
   - macro defined -> 0x00010000.
6. Handshake and reset:
   - i_valid gaps of 3 cycles mid-block -> result unchanged.
   - Hold i_ready=0 for 5 cycles in OUT -> o_valid and o_float32 stable, o_ready=0.
   - Assert i_rst after beat 4 -> outputs zero immediately; a fresh block afterwards gives the correct result.
